// File: rtl/uart_rx_fsm_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm_pkg
// Shared definitions for the UART receive controller: the FSM state encoding
// and the legal oversampling (Prescale) ratios, plus a legality helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_fsm_pkg;

    typedef logic [2:0] state_t;

    // Binary state encoding.
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;
    localparam state_t S_DONE   = 3'd5;

    // Supported oversampling ratios.
    localparam int unsigned PRESCALE_X8  = 8;
    localparam int unsigned PRESCALE_X16 = 16;
    localparam int unsigned PRESCALE_X32 = 32;

    function automatic logic is_legal_prescale(input int unsigned p);
        return (p == PRESCALE_X8) || (p == PRESCALE_X16) || (p == PRESCALE_X32);
    endfunction

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// -----------------------------------------------------------------------------
// edge_bit_counter
// Oversample (edge) and data-bit counters for the UART receive FSM.
//   i_clk, i_reset   : clock, asynchronous active-high reset
//   i_prescale       : oversampling ratio; a bit lasts i_prescale cycles
//   i_edge_en/_clr   : count oversample edges / force edge count to 0
//   i_bit_en/_clr    : advance bit index at each bit end / force it to 0
//   o_edge_cnt       : oversample index within the current bit
//   o_bit_cnt        : data bit index
//   o_bit_end        : last oversample of the current bit
//   o_last_bit       : bit index is on the final data bit
// Clear has priority over enable on both counters.
// -----------------------------------------------------------------------------
module edge_bit_counter
    import uart_rx_fsm_pkg::*;
#(
    parameter int DATA_width     = 8,
    parameter int Prescale_width = 6
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [Prescale_width-1:0] i_prescale,
    input  logic                      i_edge_en,
    input  logic                      i_edge_clr,
    input  logic                      i_bit_en,
    input  logic                      i_bit_clr,
    output logic [Prescale_width-1:0] o_edge_cnt,
    output logic [3:0]                o_bit_cnt,
    output logic                      o_bit_end,
    output logic                      o_last_bit
);

    logic [Prescale_width-1:0] r_edge_cnt;
    logic [3:0]                r_bit_cnt;
    logic [Prescale_width-1:0] w_edge_max;

    assign w_edge_max = i_prescale - 1'b1;

    // '>=' rather than '==' so a Prescale lowered mid-bit still wraps at once
    // instead of running the counter all the way round; identical for a
    // stable Prescale.
    assign o_bit_end  = (r_edge_cnt >= w_edge_max);
    assign o_last_bit = (r_bit_cnt == 4'(DATA_width - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_edge_cnt <= '0;
        end else if (i_edge_clr) begin
            r_edge_cnt <= '0;
        end else if (i_edge_en) begin
            if (o_bit_end) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bit_cnt <= '0;
        end else if (i_bit_clr) begin
            r_bit_cnt <= '0;
        end else if (i_bit_en && o_bit_end) begin
            if (o_last_bit) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;

endmodule

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// Control FSM of an oversampling UART receiver. Sequences START, DATA,
// optional PARITY, STOP and a one-cycle DONE, driving the enables of the
// external sampler/checkers/deserializer and reporting the frame outcome.
//   clk, reset        : clock, asynchronous active-high reset
//   RX_IN             : synchronised serial line (idle high)
//   PAR_EN, PAR_TYP   : parity present / parity type (used by the checker)
//   Prescale          : oversampling ratio (8, 16 or 32)
//   strt_glitch, par_err, stp_err : checker results
//   edge_cnt, bit_cnt : oversample index and data bit index
//   dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en : enables
//   data_valid, frame_err, parity_err_flag : one-cycle outcome pulses in DONE
//   busy              : high whenever not IDLE
// -----------------------------------------------------------------------------
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter int DATA_width     = 8,
    parameter int Prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [Prescale_width-1:0] Prescale,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic [Prescale_width-1:0] edge_cnt,
    output logic [3:0]                bit_cnt,
    output logic                      dat_samp_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      deser_en,
    output logic                      data_valid,
    output logic                      frame_err,
    output logic                      parity_err_flag,
    output logic                      busy
);

    state_t r_state;
    state_t w_next_state;
    logic   r_par_flag;
    logic   w_bit_end;
    logic   w_last_bit;
    logic   w_in_frame;
    logic   w_in_data;

    // Counting states: the line is being sampled, so the edge counter runs.
    assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_in_data  = (r_state == S_DATA);

    edge_bit_counter #(
        .DATA_width     (DATA_width),
        .Prescale_width (Prescale_width)
    ) u_edge_bit_counter (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_prescale (Prescale),
        .i_edge_en  (w_in_frame),
        .i_edge_clr (!w_in_frame),
        .i_bit_en   (w_in_data),
        .i_bit_clr  (!w_in_data),
        .o_edge_cnt (edge_cnt),
        .o_bit_cnt  (bit_cnt),
        .o_bit_end  (w_bit_end),
        .o_last_bit (w_last_bit)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!RX_IN) w_next_state = S_START;
            end
            S_START: begin
                if (w_bit_end) w_next_state = strt_glitch ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && w_last_bit) w_next_state = PAR_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_bit_end) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) w_next_state = S_DONE;
            end
            S_DONE: begin
                // A low line here is already the next start bit.
                w_next_state = RX_IN ? S_IDLE : S_START;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Parity result is captured once per frame and cleared in START so a
    // frame without parity never inherits the previous frame's error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_flag <= 1'b0;
        end else if (r_state == S_START) begin
            r_par_flag <= 1'b0;
        end else if ((r_state == S_PARITY) && w_bit_end) begin
            r_par_flag <= par_err;
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign dat_samp_en     = w_in_frame;
    assign strt_chk_en     = (r_state == S_START);
    assign par_chk_en      = (r_state == S_PARITY);
    assign stp_chk_en      = (r_state == S_STOP);
    assign deser_en        = w_in_data && w_bit_end;

    // Stop error outranks parity error; exactly one outcome pulse per DONE.
    assign frame_err       = (r_state == S_DONE) && stp_err;
    assign parity_err_flag = (r_state == S_DONE) && !stp_err && r_par_flag;
    assign data_valid      = (r_state == S_DONE) && !stp_err && !r_par_flag;

    // Ratio must be a supported one and the parity type must not move while
    // the parity checker is evaluating the bit.
    a_legal_prescale : assert property (@(posedge clk) disable iff (reset)
        busy |-> is_legal_prescale(32'(Prescale)));
    a_par_typ_stable : assert property (@(posedge clk) disable iff (reset)
        par_chk_en |-> $stable(PAR_TYP));

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;

    localparam int PW = 6;

    localparam logic [2:0] K_DV = 3'b100;
    localparam logic [2:0] K_FE = 3'b010;
    localparam logic [2:0] K_PE = 3'b001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [PW-1:0] Prescale = 6'd8;
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
    logic          data_valid, frame_err, parity_err_flag, busy;
    logic [8:0]    outs;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
        int         deser;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   deser_seen = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    uart_rx_fsm #(
        .DATA_width     (8),
        .Prescale_width (PW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .RX_IN           (RX_IN),
        .PAR_EN          (PAR_EN),
        .PAR_TYP         (PAR_TYP),
        .Prescale        (Prescale),
        .strt_glitch     (strt_glitch),
        .par_err         (par_err),
        .stp_err         (stp_err),
        .edge_cnt        (edge_cnt),
        .bit_cnt         (bit_cnt),
        .dat_samp_en     (dat_samp_en),
        .strt_chk_en     (strt_chk_en),
        .par_chk_en      (par_chk_en),
        .stp_chk_en      (stp_chk_en),
        .deser_en        (deser_en),
        .data_valid      (data_valid),
        .frame_err       (frame_err),
        .parity_err_flag (parity_err_flag),
        .busy            (busy)
    );

    assign outs = {busy, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
                   data_valid, frame_err, parity_err_flag};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int p, input logic par);
        return (1 + 8 + int'(par) + 1) * p;
    endfunction

    // Expected outcome pulse in the DONE cycle: first START cycle is the one
    // after the line is driven low, DONE follows a whole frame later.
    task automatic push_exp(input logic [2:0] kind, input int start_cyc, input int len);
        exp_t e;
        e.kind  = kind;
        e.cyc   = start_cyc + len;
        e.deser = 8;
        sb.push_back(e);
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_on, input logic par_bit,
                              input logic stop_bit, input int p);
        RX_IN = 1'b0;
        hold(p);
        for (int i = 0; i < 8; i++) begin
            RX_IN = data[i];
            hold(p);
        end
        if (par_on) begin
            RX_IN = par_bit;
            hold(p);
        end
        RX_IN = stop_bit;
        hold(p);
        RX_IN = 1'b1;
    endtask

    // Scoreboard side: pop an expectation on every outcome pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            deser_seen = 0;
        end else begin
            if (deser_en) deser_seen++;
            if (data_valid || frame_err || parity_err_flag) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {29'd0, data_valid, frame_err, parity_err_flag}, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", {29'd0, data_valid, frame_err, parity_err_flag},
                          {29'd0, e.kind});
                    check("pulse_cycle", cyc, e.cyc);
                    check("deser_count", deser_seen, e.deser);
                end
                deser_seen = 0;
            end
        end
    end

    initial begin
        int c0;

        // Reset state
        @(negedge clk);
        check("reset_outs", {23'd0, outs}, 0);
        check("reset_edge_cnt", {26'd0, edge_cnt}, 0);
        check("reset_bit_cnt", {28'd0, bit_cnt}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        hold(2);

        // Prescale 8, even parity, 0xA5, good stop -> data_valid after 88
        Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        push_exp(K_DV, cyc + 1, frame_len(8, 1'b1));
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1, 8);
        hold(4);
        check("sb_drained_good", sb.size(), 0);

        // Same frame, parity checker reports an error
        par_err = 1'b1;
        push_exp(K_PE, cyc + 1, frame_len(8, 1'b1));
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1, 8);
        hold(4);
        par_err = 1'b0;
        check("sb_drained_par", sb.size(), 0);

        // Start glitch: low 3 cycles, checker flags it, back to IDLE
        strt_glitch = 1'b1;
        c0 = cyc;
        RX_IN = 1'b0;
        hold(1);
        check("start_entry_enables", {29'd0, busy, dat_samp_en, strt_chk_en}, 7);
        check("start_entry_edge_cnt", {26'd0, edge_cnt}, 0);
        hold(2);
        RX_IN = 1'b1;
        hold(5);
        check("glitch_last_start_edge", {26'd0, edge_cnt}, 7);
        check("glitch_busy_before_end", {31'd0, busy}, 1);
        hold(1);
        check("glitch_idle_cycles", cyc - c0, 9);
        check("glitch_outs_idle", {23'd0, outs}, 0);
        check("glitch_no_deser", deser_seen, 0);
        strt_glitch = 1'b0;
        hold(2);

        // Prescale 16, no parity, bad stop -> frame_err after 160
        Prescale = 6'd16; PAR_EN = 1'b0; stp_err = 1'b1;
        push_exp(K_FE, cyc + 1, frame_len(16, 1'b0));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 16);
        hold(4);
        stp_err = 1'b0;
        check("sb_drained_stop", sb.size(), 0);

        // Prescale 32, both errors -> frame_err wins
        Prescale = 6'd32; PAR_EN = 1'b1; par_err = 1'b1; stp_err = 1'b1;
        push_exp(K_FE, cyc + 1, frame_len(32, 1'b1));
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 32);
        hold(4);
        par_err = 1'b0; stp_err = 1'b0;
        check("sb_drained_prio", sb.size(), 0);

        // Back-to-back frames, Prescale 8, no parity. Second START is the
        // cycle after the first DONE, so pulses are one frame plus one apart.
        Prescale = 6'd8; PAR_EN = 1'b0;
        c0 = cyc;
        push_exp(K_DV, c0 + 1, frame_len(8, 1'b0));
        push_exp(K_DV, c0 + 1 + frame_len(8, 1'b0) + 1, frame_len(8, 1'b0));
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 8);
        send_frame(8'hED, 1'b0, 1'b0, 1'b1, 8);
        hold(4);
        check("sb_drained_b2b", sb.size(), 0);

        // Reset in DATA with bit_cnt = 4
        c0 = cyc;
        RX_IN = 1'b0;
        hold(8);
        RX_IN = 1'b1;
        hold(36);
        check("mid_frame_bit_cnt", {28'd0, bit_cnt}, 4);
        check("mid_frame_busy", {31'd0, busy}, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outs", {23'd0, outs}, 0);
        check("async_reset_edge_cnt", {26'd0, edge_cnt}, 0);
        check("async_reset_bit_cnt", {28'd0, bit_cnt}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        hold(3);
        check("post_reset_idle", {23'd0, outs}, 0);

        // Next frame after reset is received normally
        push_exp(K_DV, cyc + 1, frame_len(8, 1'b0));
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 8);
        hold(4);
        check("sb_drained_final", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: observed timeout at cycle %0d, expected completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
